ball_engine: RTL
================

BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, playfield width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, playfield height in pixels.
REQ-003 SHALL have parameter BALL_SIZE, default 8, ball square side in pixels.
REQ-004 SHALL have parameters PADDLE_W, default 8, and PADDLE_H, default 64, giving paddle width and height.
REQ-005 SHALL have parameters LEFT_PADDLE_X, default 16, and RIGHT_PADDLE_X, default 616, giving each paddle's left-edge x.
REQ-006 SHALL have parameters STEP_X, default 2, and STEP_Y, default 1, giving pixels moved per tick.
REQ-007 SHALL have parameter SERVE_TICKS, default 50, giving the number of ticks the ball is held at centre before launch.
REQ-008 SHALL have port clock, input, 1 bit, system clock; the block has one clock, and all logic is clocked on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-010 SHALL have port tickIn, input, 1 bit, game-rate square wave from the clock divider, synchronous to clock.
REQ-011 SHALL have ports leftPaddleY and rightPaddleY, input, 10 bits each, giving each paddle's top-edge y.
REQ-012 SHALL have ports ballX and ballY, output, 10 bits each, giving the ball's top-left position.
REQ-013 SHALL have port ballActive, output, 1 bit, high while in PLAY.
REQ-014 SHALL have ports scoreLeft and scoreRight, output, 1 bit each, one-clock point pulses.

Function
REQ-015 SHALL derive tick = tickIn & ~tickPrev, where tickPrev is tickIn registered; all motion and counting occur only at clock edges where tick=1.
REQ-016 SHALL implement three states: SERVE, PLAY and SCORED.
REQ-017 SERVE SHALL hold ballX=(SCREEN_W-BALL_SIZE)/2 (316) and ballY=(SCREEN_H-BALL_SIZE)/2 (236), increment serveCnt per tick, and enter PLAY on the tick where serveCnt reaches SERVE_TICKS-1.
REQ-018 PLAY SHALL, per tick, add or subtract STEP_X to ballX per dirX, and STEP_Y to ballY per dirY, computing in 11-bit unsigned with no wrap-around.
REQ-019 Top wall: on dirY=up with ballY<=STEP_Y, SHALL set ballY=0 and dirY=down.
REQ-020 Bottom wall: on dirY=down with ballY+STEP_Y>=SCREEN_H-BALL_SIZE, SHALL set ballY=SCREEN_H-BALL_SIZE and dirY=up.
REQ-021 Left paddle hit, when all of the following hold: dirX=left; ballX>=LEFT_PADDLE_X+PADDLE_W; ballX-STEP_X<=LEFT_PADDLE_X+PADDLE_W; ballY+BALL_SIZE>leftPaddleY; ballY<leftPaddleY+PADDLE_H. It SHALL set ballX=LEFT_PADDLE_X+PADDLE_W and dirX=right.
REQ-022 Right paddle hit SHALL mirror REQ-021, using plane RIGHT_PADDLE_X-BALL_SIZE (608) and rightPaddleY, and SHALL set ballX=608 and dirX=left.
REQ-023 Left miss: on dirX=left with ballX<=STEP_X and no hit, SHALL pulse scoreRight for one clock, set dirX=left for the next serve, and enter SCORED.
REQ-024 Right miss: on dirX=right with ballX+STEP_X>=SCREEN_W-BALL_SIZE and no hit, SHALL pulse scoreLeft for one clock, set dirX=right for the next serve, and enter SCORED.
REQ-025 Paddle hit SHALL take priority over a miss in the same tick; wall and paddle bounces in the same tick (corner) SHALL both apply independently.
REQ-026 SCORED SHALL last exactly one clock, clear serveCnt, and go to SERVE, whether or not a tick is present.
REQ-027 Score pulses SHALL be asserted on the same edge that enters SCORED, and never more than once per point.
REQ-028 ballActive SHALL equal (state==PLAY), registered.
REQ-029 Paddle inputs SHALL be sampled only at tick edges; a paddle change between ticks SHALL have no effect.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL enter SERVE with serveCnt=0 and tickPrev=0.
REQ-031 Reset SHALL set ballX=316, ballY=236, dirX=right, dirY=down, scoreLeft=0, scoreRight=0 and ballActive=0.
REQ-032 Reset SHALL override any simultaneous tick, hit or miss, including a reset asserted mid-PLAY or in SCORED.

Structure
REQ-033 Screen, ball and paddle geometry defaults and the 2-bit state encoding SHALL live in shared package pong_pkg, which is reused by the paddle and renderer blocks.
REQ-034 Edge detection SHALL be the sub-module tick_edge (inputs clock, reset, tickIn; output tick).

Verification
REQ-035 SERVE_TICKS=3, 3 tickIn rising edges after reset -> ballActive rises on the 3rd tick; ballX=316 until the next tick, then 318 and ballY=237.
REQ-036 Ball at ballY=1, dirY=up, one tick -> ballY=0 and dirY=down; next tick ballY=1.
REQ-037 Ball at ballX=25, dirX=left, ballY=100, leftPaddleY=80, one tick -> ballX=24 and dirX=right, with no score pulse.
REQ-038 Same as REQ-037 with leftPaddleY=200 -> ball continues left; when ballX<=2, a single-cycle scoreRight pulse occurs, followed by SERVE at (316,236) with dirX=left.
REQ-039 Ball at ballX=607, ballY=472, dirX=right, dirY=down, rightPaddleY=416, one tick -> ballX=608, ballY=472, dirX=left and dirY=up.
REQ-040 Reset asserted for one clock mid-PLAY, coincident with a tick -> next state is SERVE at (316,236), ballActive=0, and no score pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared playfield geometry defaults and game state encoding
package pong_pkg;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_PADDLE_W = 8;
  localparam int DEF_PADDLE_H = 64;
  localparam int DEF_LEFT_PADDLE_X = 16;
  localparam int DEF_RIGHT_PADDLE_X = 616;
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, SCORED = 2'd2} state_t;
endpackage

// File: rtl/tick_edge.sv
// tick_edge: one-clock pulse on each rising edge of the game-rate square wave
module tick_edge (
  input  logic clock,
  input  logic reset,
  input  logic tickIn,
  output logic tick
);
  logic r_prev;
  always_ff @(posedge clock) r_prev <= reset ? 1'b0 : tickIn;
  assign tick = tickIn & ~r_prev;
endmodule

// File: rtl/ball_engine.sv
// ball_engine: ball motion, wall/paddle bounces, miss scoring and serve timing
module ball_engine import pong_pkg::*; #(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int PADDLE_W = DEF_PADDLE_W,
  parameter int PADDLE_H = DEF_PADDLE_H,
  parameter int LEFT_PADDLE_X = DEF_LEFT_PADDLE_X,
  parameter int RIGHT_PADDLE_X = DEF_RIGHT_PADDLE_X,
  parameter int STEP_X = 2,
  parameter int STEP_Y = 1,
  parameter int SERVE_TICKS = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tickIn,
  input  logic [9:0] leftPaddleY,
  input  logic [9:0] rightPaddleY,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic       ballActive,
  output logic       scoreLeft,
  output logic       scoreRight
);
  localparam logic [9:0] CX = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] CY = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] YMAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] LP = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] RP = 11'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [10:0] SX = 11'(STEP_X);
  localparam logic [10:0] SY = 11'(STEP_Y);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] PH = 11'(PADDLE_H);
  localparam int CW = $clog2(SERVE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(SERVE_TICKS - 1);
  logic w_tick;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_dx, r_dy;
  logic [10:0] w_x, w_y, w_lpy, w_rpy;
  logic w_hit_l, w_hit_r, w_miss_l, w_miss_r, w_top, w_bot;
  tick_edge u_edge (.clock(clock), .reset(reset), .tickIn(tickIn), .tick(w_tick));
  assign w_x = {1'b0, ballX};
  assign w_y = {1'b0, ballY};
  assign w_lpy = {1'b0, leftPaddleY};
  assign w_rpy = {1'b0, rightPaddleY};
  // r_dx: 1 = moving right; r_dy: 1 = moving down
  always_comb begin
    w_hit_l = !r_dx && w_x >= LP && w_x - SX <= LP && w_y + BS > w_lpy && w_y < w_lpy + PH;
    w_hit_r = r_dx && w_x <= RP && w_x + SX >= RP && w_y + BS > w_rpy && w_y < w_rpy + PH;
    w_miss_l = !r_dx && w_x <= SX && !w_hit_l;
    w_miss_r = r_dx && w_x + SX >= XMAX && !w_hit_r;
    w_top = !r_dy && w_y <= SY;
    w_bot = r_dy && w_y + SY >= YMAX;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SERVE;
      r_cnt <= '0;
      ballX <= CX;
      ballY <= CY;
      r_dx <= 1'b1;
      r_dy <= 1'b1;
      scoreLeft <= 1'b0;
      scoreRight <= 1'b0;
      ballActive <= 1'b0;
    end else begin
      scoreLeft <= 1'b0;
      scoreRight <= 1'b0;
      case (r_state)
        SERVE: begin
          ballX <= CX;
          ballY <= CY;
          if (w_tick) begin
            if (r_cnt == LAST) begin
              r_state <= PLAY;
              ballActive <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
        end
        PLAY: if (w_tick) begin
          r_dy <= w_top ? 1'b1 : w_bot ? 1'b0 : r_dy;
          if (w_miss_l || w_miss_r) begin
            r_state <= SCORED;
            ballActive <= 1'b0;
            scoreRight <= w_miss_l;
            scoreLeft <= w_miss_r;
            r_dx <= w_miss_r;
            ballX <= CX;
            ballY <= CY;
          end else begin
            ballX <= 10'(w_hit_l ? LP : w_hit_r ? RP : r_dx ? w_x + SX : w_x - SX);
            ballY <= 10'(w_top ? 11'd0 : w_bot ? YMAX : r_dy ? w_y + SY : w_y - SY);
            r_dx <= w_hit_l ? 1'b1 : w_hit_r ? 1'b0 : r_dx;
          end
        end
        default: begin
          r_state <= SERVE;
          r_cnt <= '0;
        end
      endcase
    end
  end
endmodule
